instr_encoder: RTL and testbench

Hardware instruction encoder for the RISC-V Atom core: the inverse of the instruction decoder. It accepts decoded instruction fields (class, rd, rs1, rs2, func3, alt bit, 32-bit immediate) over a valid/ready handshake and emits packed RV32I instruction words over a second valid/ready handshake. It also expands the `LI` pseudo-instruction into one or two words. It sits between the debug/boot command path and the instruction injection port.

---
 rtl/instr_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and expands LI into LUI/ADDI.
// Define ENC_XCUSTOM_EN to make op 10 emit the custom-0 R-type word; otherwise op 10 is illegal.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [2:0]  req_f3_i,
  input  logic        req_alt_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rs1_i,
  input  logic [4:0]  req_rs2_i,
  input  logic [31:0] req_imm_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic        dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holding valid keeps its payload stable until that edge.

  localparam logic [3:0] CL_LUI     = 4'd0;
  localparam logic [3:0] CL_AUIPC   = 4'd1;
  localparam logic [3:0] CL_JAL     = 4'd2;
  localparam logic [3:0] CL_JALR    = 4'd3;
  localparam logic [3:0] CL_BRANCH  = 4'd4;
  localparam logic [3:0] CL_LOAD    = 4'd5;
  localparam logic [3:0] CL_STORE   = 4'd6;
  localparam logic [3:0] CL_OPIMM   = 4'd7;
  localparam logic [3:0] CL_OP      = 4'd8;
  localparam logic [3:0] CL_LI      = 4'd9;
  localparam logic [3:0] CL_XCUSTOM = 4'd10;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_XCUSTOM = 7'b0001011;

  typedef enum logic {
    IDLE  = 1'b0,
    LI_LO = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Format packers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] pack_u(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm[31:12], rd, opc};
  endfunction

  function automatic logic [31:0] pack_j(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  function automatic logic [31:0] pack_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] pack_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode: first word, optional second word, legality
  // ---------------------------------------------------------------------------
  logic [31:0] word_a;
  logic [31:0] word_b;
  logic        two_words;
  logic        illegal;
  logic        li_small;
  logic [19:0] li_hi;
  logic        shift_imm;
  logic [6:0]  alt_f7;

  // LI fits a single ADDI when the value is the sign extension of its low 12 bits.
  assign li_small  = (req_imm_i == {{20{req_imm_i[11]}}, req_imm_i[11:0]});
  // ADDI sign-extends its 12-bit operand, so the upper part is rounded up when bit 11 is set.
  assign li_hi     = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
  assign shift_imm = (req_f3_i == 3'b001) || (req_f3_i == 3'b101);
  assign alt_f7    = {1'b0, req_alt_i, 5'd0};

  always_comb begin
    word_a    = '0;
    word_b    = '0;
    two_words = 1'b0;
    illegal   = 1'b0;
    case (req_op_i)
      CL_LUI:    word_a = pack_u(req_imm_i, req_rd_i, OPC_LUI);
      CL_AUIPC:  word_a = pack_u(req_imm_i, req_rd_i, OPC_AUIPC);
      CL_JAL:    word_a = pack_j(req_imm_i, req_rd_i, OPC_JAL);
      CL_JALR:   word_a = pack_i(req_imm_i, req_rs1_i, 3'b000, req_rd_i, OPC_JALR);
      CL_BRANCH: word_a = pack_b(req_imm_i, req_rs2_i, req_rs1_i, req_f3_i, OPC_BRANCH);
      CL_LOAD:   word_a = pack_i(req_imm_i, req_rs1_i, req_f3_i, req_rd_i, OPC_LOAD);
      CL_STORE:  word_a = pack_s(req_imm_i, req_rs2_i, req_rs1_i, req_f3_i, OPC_STORE);
      CL_OPIMM: begin
        if (shift_imm) begin
          word_a = pack_r(alt_f7, req_imm_i[4:0], req_rs1_i, req_f3_i, req_rd_i, OPC_OPIMM);
        end else begin
          word_a = pack_i(req_imm_i, req_rs1_i, req_f3_i, req_rd_i, OPC_OPIMM);
        end
      end
      CL_OP:     word_a = pack_r(alt_f7, req_rs2_i, req_rs1_i, req_f3_i, req_rd_i, OPC_OP);
      CL_LI: begin
        if (li_small) begin
          word_a = pack_i(req_imm_i, 5'd0, 3'b000, req_rd_i, OPC_OPIMM);
        end else begin
          word_a    = {li_hi, req_rd_i, OPC_LUI};
          word_b    = pack_i(req_imm_i, req_rd_i, 3'b000, req_rd_i, OPC_OPIMM);
          two_words = (req_imm_i[11:0] != 12'd0);
        end
      end
`ifdef ENC_XCUSTOM_EN
      CL_XCUSTOM: word_a = pack_r(7'd0, req_rs2_i, req_rs1_i, req_f3_i, req_rd_i, OPC_XCUSTOM);
`else
      CL_XCUSTOM: illegal = 1'b1;
`endif
      default:   illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output slot control
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_n;
  logic [31:0] pend;
  logic [31:0] pend_n;
  logic [31:0] instr_n;
  logic        valid_n;
  logic        err_n;
  logic        slot_free;
  logic        accept;

  assign slot_free   = !instr_valid_o || instr_ready_i;
  assign req_ready_o = (state == IDLE) && slot_free && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign dbg_state_o = (state == LI_LO);

  always_comb begin
    state_n = state;
    pend_n  = pend;
    instr_n = instr_o;
    valid_n = instr_valid_o && !instr_ready_i;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_n = 1'b1;
          end else begin
            instr_n = word_a;
            valid_n = 1'b1;
            if (two_words) begin
              pend_n  = word_b;
              state_n = LI_LO;
            end
          end
        end
      end
      LI_LO: begin
        if (slot_free) begin
          instr_n = pend;
          valid_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      pend          <= '0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state         <= state_n;
      pend          <= pend_n;
      instr_o       <= instr_n;
      instr_valid_o <= valid_n;
      err_o         <= err_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases from the encoding rules plus
// randomized requests scored against a field-arithmetic reference model.
module tb_instr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_op_i = '0;
  logic [2:0]  req_f3_i = '0;
  logic        req_alt_i = 1'b0;
  logic [4:0]  req_rd_i = '0;
  logic [4:0]  req_rs1_i = '0;
  logic [4:0]  req_rs2_i = '0;
  logic [31:0] req_imm_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic        err_o;
  logic        dbg_state_o;

  instr_encoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_f3_i      (req_f3_i),
    .req_alt_i     (req_alt_i),
    .req_rd_i      (req_rd_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_imm_i     (req_imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .err_o         (err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------------------------------------------------------- clock / reset
  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  bit          err_exp = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------- reference model
  // n = number of emitted words; 0 means the request is illegal.
  function automatic void model(input int op, input logic [31:0] f3, input logic [31:0] alt,
                                input logic [31:0] rd, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                output int n, output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] lo12;
    logic [31:0] hi;
    lo12 = imm & 32'hFFF;
    w0 = '0;
    w1 = '0;
    n  = 1;
    case (op)
      0: w0 = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
      1: w0 = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
      2: w0 = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12)
            | (rd << 7) | 32'h6F;
      3: w0 = (lo12 << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      4: w0 = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
            | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'h63;
      5: w0 = (lo12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      6: w0 = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((imm & 32'h1F) << 7) | 32'h23;
      7: begin
        if (f3 == 32'd1 || f3 == 32'd5)
          w0 = (alt << 30) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        else
          w0 = (lo12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      end
      8: w0 = (alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      9: begin
        if ($signed(imm) >= -2048 && $signed(imm) <= 2047) begin
          w0 = (lo12 << 20) | (rd << 7) | 32'h13;
        end else begin
          hi = ((imm + 32'h800) >> 12) & 32'hFFFFF;
          w0 = (hi << 12) | (rd << 7) | 32'h37;
          if (lo12 != 0) begin
            n  = 2;
            w1 = (lo12 << 20) | (rd << 15) | (rd << 7) | 32'h13;
          end
        end
      end
`ifdef ENC_XCUSTOM_EN
      10: w0 = (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h0B;
`else
      10: n = 0;
`endif
      default: n = 0;
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk_i) begin : monitor
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    if (rst_i) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      check("err_pulse", {31'd0, err_o}, {31'd0, err_exp});
      err_exp = 1'b0;
      if (instr_valid_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", {31'd0, instr_valid_o}, 32'd0);
        end else begin
          check("word", instr_o, exp_q[0]);
          if (instr_ready_i) void'(exp_q.pop_front());
        end
      end
      if (req_valid_i && req_ready_o) begin
        model(int'(req_op_i), 32'(req_f3_i), 32'(req_alt_i), 32'(req_rd_i),
              32'(req_rs1_i), 32'(req_rs2_i), req_imm_i, n, w0, w1);
        if (n == 0) err_exp = 1'b1;
        else begin
          exp_q.push_back(w0);
          if (n == 2) exp_q.push_back(w1);
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (rand_ready) begin
      #1;
      instr_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // Called just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    req_op_i  = op;
    req_f3_i  = f3;
    req_alt_i = alt;
    req_rd_i  = rd;
    req_rs1_i = rs1;
    req_rs2_i = rs2;
    req_imm_i = imm;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) check("req_timeout", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] edge_imm[6] = '{32'h000007FF, 32'h00000800, 32'hFFFFF800,
                               32'hFFFFF7FF, 32'h7FFFF800, 32'h80000000};

  initial begin
    int          k;
    logic [3:0]  op;
    logic [31:0] imm;

    #2 rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_state", {31'd0, dbg_state_o}, 32'd0);
    step();
    rst_i = 1'b0;
    step();

    // ADDI x1, x0, 5
    send(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    check("addi_valid", {31'd0, instr_valid_o}, 32'd1);
    check("addi_word", instr_o, 32'h00500093);
    step();
    check("addi_drop", {31'd0, instr_valid_o}, 32'd0);

    // Two-word LI
    send(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    check("li_lui", instr_o, 32'h123462B7);
    check("li_lo_ready", {31'd0, req_ready_o}, 32'd0);
    check("li_lo_state", {31'd0, dbg_state_o}, 32'd1);
    step();
    check("li_addi", instr_o, 32'hFFF28293);
    check("li_addi_valid", {31'd0, instr_valid_o}, 32'd1);
    step();

    // Single-word LI cases
    send(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00000123);
    check("li_small", instr_o, 32'h12300293);
    step();
    check("li_small_one", {31'd0, instr_valid_o}, 32'd0);
    send(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00010000);
    check("li_lui_only", instr_o, 32'h000102B7);
    step();
    check("li_lui_one", {31'd0, instr_valid_o}, 32'd0);

    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    check("branch_word", instr_o, 32'hFE208EE3);
    step();

    // Backpressure
    instr_ready_i = 1'b0;
    send(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", instr_o, 32'h00500093);
      check("bp_valid", {31'd0, instr_valid_o}, 32'd1);
      check("bp_ready", {31'd0, req_ready_o}, 32'd0);
    end
    req_op_i = 4'd8; req_f3_i = 3'd0; req_alt_i = 1'b1;
    req_rd_i = 5'd3; req_rs1_i = 5'd1; req_rs2_i = 5'd2; req_imm_i = '0;
    req_valid_i = 1'b1;
    instr_ready_i = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, req_ready_o}, 32'd1);
    send(4'd8, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    check("sub_word", instr_o, 32'h402081B3);
    step();

    // Reset while the ADDI half of an LI is pending
    send(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    rst_i = 1'b1;
    #1;
    check("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("midrst_ready", {31'd0, req_ready_o}, 32'd0);
    step();
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_quiet", {31'd0, instr_valid_o}, 32'd0);
    end

    // Illegal op
    send(4'd15, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    check("illegal_err", {31'd0, err_o}, 32'd1);
    check("illegal_novalid", {31'd0, instr_valid_o}, 32'd0);
    step();
    check("illegal_err_clear", {31'd0, err_o}, 32'd0);

    send(4'd10, 3'd1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
`ifdef ENC_XCUSTOM_EN
    check("xadd_word", instr_o, 32'h0020918B);
    check("xadd_valid", {31'd0, instr_valid_o}, 32'd1);
`else
    check("xcustom_err", {31'd0, err_o}, 32'd1);
    check("xcustom_novalid", {31'd0, instr_valid_o}, 32'd0);
`endif
    step();

    // Randomized traffic with random downstream stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 10));
      k = $urandom_range(0, 3);
      case (k)
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = $urandom & 32'hFFFFF000;
        2: imm = $urandom;
        default: imm = edge_imm[$urandom_range(0, 5)];
      endcase
      send(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
      if ($urandom_range(0, 3) == 0) step();
    end

    // Drain
    rand_ready = 1'b0;
    @(posedge clk_i);
    #2;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
